rf_write_arb: RTL
=================

RF_WRITE_ARB -- requirements
Module: rf_write_arb

Interface
REQ-001 SHALL have parameters: W, default 8, data path width; D, default 4, register address width.
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-004 SHALL have port start  input  1  testbench start pulse.
REQ-005 SHALL have ports alu_req  input  1; alu_addr  input  D; alu_data  input  W; alu_zero  input  1; alu_done  input  1: ALU writeback request, destination, value, zero flag, halt flag.
REQ-006 SHALL have ports mem_req  input  1; mem_addr  input  D; mem_data  input  W: load-unit writeback request, destination, value.
REQ-007 SHALL have ports alu_gnt  output  1 and mem_gnt  output  1: combinational grants, same cycle as the accepted request.
REQ-008 SHALL have ports WriteEn  output  1; Waddr  output  D; DataIn  output  W; Zero_in  output  1; Done_in  output  1: registered register-file write port.
REQ-009 SHALL have ports running  output  1 (FSM in RUN) and last_gnt  output  1 (0 = ALU, 1 = MEM).

Function
REQ-010 SHALL implement a two-state FSM: HALT (reset state) and RUN.
REQ-011 In HALT, SHALL hold alu_gnt = mem_gnt = 0 and drive WriteEn = 0, Waddr = 0, DataIn = 0, Zero_in = 0, Done_in = 0; pending requests stay ungranted.
REQ-012 HALT -> RUN when start = 1 at a rising edge; start SHALL be ignored in RUN.
REQ-013 In RUN, SHALL assert at most one grant per cycle, and only to a requester whose req = 1.
REQ-014 With exactly one requester active, SHALL grant it.
REQ-015 With both active, SHALL grant the requester not named by last_gnt (round-robin); worst-case wait is 1 cycle.
REQ-016 last_gnt SHALL update to the granted requester at the edge ending the grant cycle; it is unchanged when there is no grant.
REQ-017 Requesters SHALL hold req, addr and data stable until granted; the arbiter samples them only in the grant cycle.
REQ-018 Latency SHALL be exactly 1 cycle: a grant in cycle n gives WriteEn = 1 in cycle n+1 with the captured Waddr and DataIn.
REQ-019 With no grant in cycle n, WriteEn SHALL be 0 in cycle n+1; Waddr and DataIn hold their previous values.
REQ-020 An ALU grant SHALL drive Zero_in = alu_zero and Done_in = alu_done, and SHALL load zero_shadow with alu_zero.
REQ-021 A MEM grant SHALL drive Zero_in = zero_shadow (flag preserved) and Done_in = 0; zero_shadow is unchanged.
REQ-022 An ALU grant with alu_done = 1 SHALL move the FSM RUN -> HALT at the same edge that registers the write.
- The halting write still appears in cycle n+1.
- No further grants are issued, even if mem_req is pending.
REQ-023 A back-to-back grant to the same requester in consecutive cycles SHALL produce WriteEn high in consecutive cycles with no bubble.
REQ-024 Widths SHALL be exact: no truncation or extension of addr or data.

Reset
REQ-025 Reset SHALL dominate start and all requests.
REQ-026 Reset SHALL set FSM = HALT, last_gnt = 1 (the ALU wins the first contention), zero_shadow = 0, and every registered output to 0.
REQ-027 Reset asserted mid-RUN SHALL discard any in-flight write: WriteEn = 0 in the next cycle and no grant during Reset.

Verification
REQ-028 Reset, then alu_req = 1 without start -> alu_gnt stays 0 for 5 cycles and WriteEn stays 0.
REQ-029 start pulse, then alu_req with addr = 3, data = 0x5A, zero = 0 -> alu_gnt = 1 in that cycle; next cycle WriteEn = 1, Waddr = 3, DataIn = 0x5A, Zero_in = 0, Done_in = 0.
REQ-030 In RUN, alu_req and mem_req held together for 4 cycles -> grant order ALU, MEM, ALU, MEM, with WriteEn high for 4 consecutive cycles.
REQ-031 ALU write with zero = 1, then mem write addr = 7, data = 0x00 -> the mem write cycle shows Zero_in = 1 and Done_in = 0.
REQ-032 ALU write with done = 1 while mem_req = 1 -> Done_in = 1 in the next cycle, running = 0, and mem_gnt never asserts; a new start resumes and grants MEM.
REQ-033 Reset asserted in the cycle after a grant while both requests are active -> WriteEn = 0, running = 0, no grants; after start, a contention cycle grants ALU first.

Source files
------------

// File: rtl/rf_write_arb.sv
// Register-file writeback arbiter: round-robin between ALU and load unit,
// one registered write per cycle, gated by a HALT/RUN FSM.
module rf_write_arb #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic         alu_req,
  input  logic [D-1:0] alu_addr,
  input  logic [W-1:0] alu_data,
  input  logic         alu_zero,
  input  logic         alu_done,
  input  logic         mem_req,
  input  logic [D-1:0] mem_addr,
  input  logic [W-1:0] mem_data,
  output logic         alu_gnt,
  output logic         mem_gnt,
  output logic         WriteEn,
  output logic [D-1:0] Waddr,
  output logic [W-1:0] DataIn,
  output logic         Zero_in,
  output logic         Done_in,
  output logic         running,
  output logic         last_gnt
);

  typedef enum logic {HALT = 1'b0, RUN = 1'b1} state_t;

  state_t state;
  logic   zero_shadow;

  assign running = (state == RUN);

  // last_gnt = 1 means MEM won last, so ALU wins the next contention.
  always_comb begin
    alu_gnt = running && !Reset && alu_req && (!mem_req || last_gnt);
    mem_gnt = running && !Reset && mem_req && (!alu_req || !last_gnt);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= HALT;
      last_gnt    <= 1'b1;
      zero_shadow <= 1'b0;
      WriteEn     <= 1'b0;
      Waddr       <= '0;
      DataIn      <= '0;
      Zero_in     <= 1'b0;
      Done_in     <= 1'b0;
    end else begin
      case (state)
        HALT: begin
          WriteEn <= 1'b0;
          Waddr   <= '0;
          DataIn  <= '0;
          Zero_in <= 1'b0;
          Done_in <= 1'b0;
          if (start) state <= RUN;
        end
        RUN: begin
          WriteEn <= alu_gnt | mem_gnt;
          if (alu_gnt) begin
            Waddr       <= alu_addr;
            DataIn      <= alu_data;
            Zero_in     <= alu_zero;
            Done_in     <= alu_done;
            zero_shadow <= alu_zero;
            last_gnt    <= 1'b0;
            // Halting write still registers at this edge.
            if (alu_done) state <= HALT;
          end else if (mem_gnt) begin
            Waddr    <= mem_addr;
            DataIn   <= mem_data;
            Zero_in  <= zero_shadow;
            Done_in  <= 1'b0;
            last_gnt <= 1'b1;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule
